// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared encodings for the jk command sequencer: opcodes, FSM states and the
// opcode to {j,k} mapping used when a command is issued.
package jk_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_e;

    // Returns {j, k} for the addressed flop.
    function automatic logic [1:0] op_jk(input jk_op_e op);
        logic [1:0] jk;
        case (op)
            OP_HOLD:   jk = 2'b00;
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO. The head entry is presented combinationally so the
// sequencer can pop and act on it in the same cycle.
module jk_cmd_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_en;
    logic          pop_en;

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers {op, idx, rpt} commands and replays each as registered one-cycle j/k
// pulses on the addressed flop, with an all-zero cycle between any two issues.
module jk_cmd_sequencer
    import jk_cmd_sequencer_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int RPT_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [RPT_W-1:0] cmd_rpt,
    output logic [N-1:0]     j,
    output logic [N-1:0]     k,
    output logic             busy,
    output logic             done,
    output logic             err_idx
);

    localparam int W  = 2 + IDX_W + RPT_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N);

    logic [W-1:0]     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;

    jk_op_e           head_op;
    logic [IDX_W-1:0] head_idx;
    logic [RPT_W-1:0] head_rpt;
    logic             head_bad;
    logic [RPT_W-1:0] head_rem;
    logic [N-1:0]     head_sel;
    logic [N-1:0]     cur_sel;

    seq_state_e       state_reg, state_next;
    jk_op_e           cur_op_reg, cur_op_next;
    logic [IDX_W-1:0] cur_idx_reg, cur_idx_next;
    logic [RPT_W-1:0] cur_rem_reg, cur_rem_next;
    logic [N-1:0]     j_reg, j_next;
    logic [N-1:0]     k_reg, k_next;
    logic             err_reg, err_next;
    logic [1:0]       jk_sel;

    assign cmd_ready = !fifo_full && !reset;
    assign push      = cmd_valid && cmd_ready;

    jk_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd_op, cmd_idx, cmd_rpt}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_op  = jk_op_e'(head[W-1 -: 2]);
    assign head_idx = head[RPT_W +: IDX_W];
    assign head_rpt = head[RPT_W-1:0];
    assign head_bad = ({1'b0, head_idx} >= N_LIM);
    // Only TOGGLE repeats; a zero repeat count still issues once.
    assign head_rem = (head_op == OP_TOGGLE && head_rpt != '0) ? head_rpt : RPT_W'(1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign head_sel[gi] = (head_idx == IDX_W'(gi));
            assign cur_sel[gi]  = (cur_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cur_op_next  = cur_op_reg;
        cur_idx_next = cur_idx_reg;
        cur_rem_next = cur_rem_reg;
        j_next       = '0;
        k_next       = '0;
        err_next     = 1'b0;
        pop          = 1'b0;
        jk_sel       = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        err_next = 1'b1;
                    end else begin
                        cur_op_next  = head_op;
                        cur_idx_next = head_idx;
                        cur_rem_next = head_rem;
                        jk_sel       = op_jk(head_op);
                        j_next       = head_sel & {N{jk_sel[1]}};
                        k_next       = head_sel & {N{jk_sel[0]}};
                        state_next   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cur_rem_reg == RPT_W'(1)) begin
                    state_next = ST_IDLE;
                end else begin
                    cur_rem_next = cur_rem_reg - RPT_W'(1);
                    state_next   = ST_GAP;
                end
            end
            ST_GAP: begin
                jk_sel     = op_jk(cur_op_reg);
                j_next     = cur_sel & {N{jk_sel[1]}};
                k_next     = cur_sel & {N{jk_sel[0]}};
                state_next = ST_ISSUE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cur_op_reg  <= OP_HOLD;
            cur_idx_reg <= '0;
            cur_rem_reg <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_op_reg  <= cur_op_next;
            cur_idx_reg <= cur_idx_next;
            cur_rem_reg <= cur_rem_next;
            j_reg       <= j_next;
            k_reg       <= k_next;
            err_reg     <= err_next;
        end
    end

    assign j       = j_reg;
    assign k       = k_reg;
    assign err_idx = err_reg;
    assign done    = (state_reg == ST_ISSUE) && (cur_rem_reg == RPT_W'(1));
    assign busy    = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: each accepted command queues its
// expected issue/err events, which are compared as the DUT produces them.
module tb_jk_cmd_sequencer;

    localparam int N     = 8;
    localparam int IDX_W = 4;
    localparam int RPT_W = 4;
    localparam int DEPTH = 4;

    localparam logic [1:0] T_HOLD   = 2'b00;
    localparam logic [1:0] T_RESET  = 2'b01;
    localparam logic [1:0] T_SET    = 2'b10;
    localparam logic [1:0] T_TOGGLE = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [IDX_W-1:0] cmd_idx = '0;
    logic [RPT_W-1:0] cmd_rpt = '0;
    logic [N-1:0]     j;
    logic [N-1:0]     k;
    logic             busy;
    logic             done;
    logic             err_idx;

    jk_cmd_sequencer #(
        .N     (N),
        .IDX_W (IDX_W),
        .RPT_W (RPT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_rpt   (cmd_rpt),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err_idx   (err_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] j;
        logic [N-1:0] k;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   ev_cyc[$];
    int   ev_count = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_issue = 1'b0;
    logic issue;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: any issue cycle or err pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            prev_issue = 1'b0;
        end else begin
            issue = (j != '0) || (k != '0) || done;
            if (issue && prev_issue) chk("spacing", 32'd1, 32'd0);
            prev_issue = issue;
            if (issue || err_idx) begin
                ev_count++;
                ev_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("sb_extra", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_j", 32'(j), 32'(e.j));
                    chk("sb_k", 32'(k), 32'(e.k));
                    chk("sb_done", 32'(done), 32'(e.done));
                    chk("sb_err", 32'(err_idx), 32'(e.err));
                end
            end
        end
    end

    task automatic push_cmd(input logic [1:0] op, input int idx, input int rpt,
                            output int hs, output int stalls);
        logic [N-1:0] m;
        exp_t x;
        int n;
        hs = -1;
        stalls = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = IDX_W'(idx);
        cmd_rpt   = RPT_W'(rpt);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                hs = cyc;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (hs < 0) begin
            chk("push_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        $display("push op=%0d idx=%0d rpt=%0d cycle=%0d stalls=%0d", op, idx, rpt, hs, stalls);
        if (idx >= N) begin
            x = '{j: '0, k: '0, done: 1'b0, err: 1'b1};
            sb.push_back(x);
        end else begin
            m = '0;
            m[idx] = 1'b1;
            n = (op == T_TOGGLE) ? ((rpt == 0) ? 1 : rpt) : 1;
            for (int i = 0; i < n; i++) begin
                x.j    = (op == T_SET || op == T_TOGGLE) ? m : '0;
                x.k    = (op == T_RESET || op == T_TOGGLE) ? m : '0;
                x.done = (i == n - 1);
                x.err  = 1'b0;
                sb.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #2;
            if (!busy && sb.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        chk(tag, 32'(idle), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int ev_at(input int i);
        return (i < ev_cyc.size()) ? ev_cyc[i] : -1;
    endfunction

    int hs, hs_a, st, stall_sum, base, base2;
    logic reached;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_j", 32'(j), 32'd0);
        chk("rst_k", 32'(k), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_idx), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: SET idx 2, latency two cycles
        ev_cyc.delete();
        push_cmd(T_SET, 2, 0, hs, st);
        wait_idle("t1_idle");
        chk("t1_events", 32'(ev_cyc.size()), 32'd1);
        chk("t1_latency", 32'(ev_at(0)), 32'(hs + 2));

        // 2: TOGGLE rpt 3 pulse train
        ev_cyc.delete();
        push_cmd(T_TOGGLE, 0, 3, hs, st);
        wait_idle("t2_idle");
        chk("t2_events", 32'(ev_cyc.size()), 32'd3);
        chk("t2_cyc0", 32'(ev_at(0)), 32'(hs + 2));
        chk("t2_cyc1", 32'(ev_at(1)), 32'(hs + 4));
        chk("t2_cyc2", 32'(ev_at(2)), 32'(hs + 6));

        // 3: back-to-back long toggles fill the FIFO
        ev_cyc.delete();
        stall_sum = 0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(T_TOGGLE, i, 15, hs, st);
            stall_sum += st;
        end
        chk("t3_nostall", 32'(stall_sum), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        push_cmd(T_TOGGLE, 5, 15, hs, st);
        chk("t3_stall", 32'(st > 0), 32'd1);
        wait_idle("t3_idle");
        chk("t3_events", 32'(ev_cyc.size()), 32'd90);

        // 4: out-of-range index dropped, next command still issues
        ev_cyc.delete();
        push_cmd(T_RESET, 9, 0, hs_a, st);
        push_cmd(T_SET, 1, 0, hs, st);
        wait_idle("t4_idle");
        chk("t4_events", 32'(ev_cyc.size()), 32'd2);
        chk("t4_err_cyc", 32'(ev_at(0)), 32'(hs_a + 2));

        // 5: reset during a TOGGLE gap with two commands queued
        base = ev_count;
        push_cmd(T_TOGGLE, 5, 5, hs, st);
        push_cmd(T_SET, 1, 0, hs, st);
        push_cmd(T_SET, 2, 0, hs, st);
        reached = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (ev_count >= base + 2) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t5_reach_gap", 32'(reached), 32'd1);
        #1;
        reset = 1'b1;
        sb.delete();
        $display("reset asserted cycle=%0d", cyc);
        @(posedge clk);
        @(negedge clk);
        chk("t5_j", 32'(j), 32'd0);
        chk("t5_k", 32'(k), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        chk("t5_busy_rel", 32'(busy), 32'd0);
        base2 = ev_count;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_quiet", 32'(ev_count - base2), 32'd0);

        // 6: TOGGLE rpt 0 issues once, HOLD issues with done only
        ev_cyc.delete();
        push_cmd(T_TOGGLE, 7, 0, hs, st);
        push_cmd(T_HOLD, 3, 0, hs, st);
        wait_idle("t6_idle");
        chk("t6_events", 32'(ev_cyc.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
